// File: rtl/disp_pkg.sv
// Shared 7-segment types and the active-low gfedcba hex glyph table.
package disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  localparam seg7_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-nibble to active-low gfedcba segment pattern.
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/hex_history_display.sv
// Keeps the last DIGITS distinct stepper values (newest first) and scans them onto
// a multiplexed common-anode 7-segment display. Macro HEX_HISTORY_BLANK_LEADING_EN
// blanks digits that hold no captured value yet.
module hex_history_display
  import disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        value,
  input  logic              sample,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int FILL_W = $clog2(DIGITS + 1);

  // sample is a plain qualifier with no backpressure: value is taken on any
  // cycle where sample=1, and only a change from the newest entry is stored.
  logic [3:0]        hist_q [DIGITS];
  logic [3:0]        hist_d [DIGITS];
  logic              have_value_q, have_value_d;
  logic              fresh_q, fresh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  seg7_t             seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              dp_q, dp_d;
`ifdef HEX_HISTORY_BLANK_LEADING_EN
  logic [FILL_W-1:0] fill_q, fill_d;
`endif

  logic  push;
  logic  wrap;
  logic  frame_end;
  seg7_t cur_glyph;

  assign push      = sample && (!have_value_q || (value != hist_q[0]));
  assign wrap      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = wrap && (idx_q == IDX_W'(DIGITS - 1));

  seg7_decoder u_dec (
    .hex (hist_q[idx_q]),
    .seg (cur_glyph)
  );

  always_comb begin
    hist_d       = hist_q;
    have_value_d = have_value_q;
    fresh_d      = fresh_q;
    cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
`ifdef HEX_HISTORY_BLANK_LEADING_EN
    fill_d = fill_q;
`endif
    // Boundary clear first so a push on the same cycle keeps fresh set.
    if (frame_end) fresh_d = 1'b0;
    if (push) begin
      for (int i = DIGITS - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0]    = value;
      have_value_d = 1'b1;
      fresh_d      = 1'b1;
`ifdef HEX_HISTORY_BLANK_LEADING_EN
      if (fill_q != FILL_W'(DIGITS)) fill_d = fill_q + FILL_W'(1);
`endif
    end
    seg_d = cur_glyph;
`ifdef HEX_HISTORY_BLANK_LEADING_EN
    if (FILL_W'(idx_q) >= fill_q) seg_d = SEG_BLANK;
`endif
    an_d = ~(DIGITS'(1) << idx_q);
    dp_d = !((idx_q == '0) && fresh_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) hist_q[i] <= 4'h0;
      have_value_q <= 1'b0;
      fresh_q      <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      dp_q         <= 1'b1;
`ifdef HEX_HISTORY_BLANK_LEADING_EN
      fill_q       <= '0;
`endif
    end else begin
      hist_q       <= hist_d;
      have_value_q <= have_value_d;
      fresh_q      <= fresh_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
`ifdef HEX_HISTORY_BLANK_LEADING_EN
      fill_q       <= fill_d;
`endif
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: doc/hex_history_display.md
Name: hex_history_display

Overview:
- Downstream consumer of the 4-bit sequence-stepper output (`value`).
- Captures every change of the stepped value into a small history register, newest first.
- Drives a multiplexed, common-anode 7-segment display so the last DIGITS values are visible at once.
- Sits between the stepper and the board display pins.

Parameters:
- DIGITS, 4, number of display digits and history depth (2..8).
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2). The bench uses 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous and active-low (asserted when 0, released synchronously by design).
- value  input  4  stepped value from upstream.
- sample  input  1  when 1, `value` is sampled this cycle.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  DIGITS  digit enables, active-low, one-cold.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset values (rst=0, immediate):
  - history all 0, fill=0, have_value=0, fresh=0.
  - refresh counter 0, digit index 0.
  - seg=7'h7F (blank), an all 1, dp=1.
- Capture, on a cycle with sample=1:
  - Push if have_value=0, or if value != hist[0].
  - Push: hist[i] <= hist[i-1] for i=1..DIGITS-1; hist[0] <= value.
  - Push also sets have_value=1 and fresh=1, and increments fill, saturating at DIGITS.
  - Equal value: no push, no state change.
  - sample=0: hold.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments modulo DIGITS (DIGITS-1 -> 0 is a frame boundary).
- Outputs are registered, with one cycle of latency from digit index and history:
  - an = one-cold of digit index.
  - seg = hex decode of hist[index].
  - Digit 0 is rightmost and newest.
- Hex decode (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- dp:
  - dp=0 only while digit 0 is lit and fresh=1; otherwise 1.
  - fresh clears at the first frame boundary after it was set.
  - A push coinciding with a frame boundary leaves fresh=1 (set wins).
- Boundaries:
  - History full: the oldest entry is dropped on push.
  - A push in the same cycle the current digit is displayed takes effect on seg the next cycle.
  - Reset mid-scan or mid-push restores the reset values immediately. No partial shift survives.

Optional Feature:
- Macro: HEX_HISTORY_BLANK_LEADING_EN.
- Defined: digits with index >= fill show seg=7'h7F, so unfilled history is blank. Before the first push the whole display is blank.
- Undefined: all digits always decode history (zeros show as "0"). The fill counter may be optimised away.

Decomposition:
- Package disp_pkg holds:
  - seg7_t typedef (logic [6:0]).
  - SEG_BLANK constant.
  - 16-entry SEG_HEX localparam table.
- Sub-module seg7_decoder (4-bit in, seg7_t out, combinational, table lookup).
- hex_history_display holds capture, scan, fresh and fill logic, plus the output registers.

Test Plan:
Bench settings: DIGITS=4, REFRESH_DIV=4.
1. Reset:
   - Stimulus: rst=0 with clk running.
   - Required: seg=7F, an=F, dp=1 throughout.
   - After release: an walks E,D,B,7, each held 4 cycles, repeating.
2. Push sequence:
   - Stimulus: sample pulses with values 4, 8, C, 0.
   - Required: digits 3..0 show 4, 8, C, 0. Digit 0 seg=40, digit 1 seg=46.
3. Repeat suppression:
   - Stimulus: after 8, sample 8 three times.
   - Required: history unchanged and fresh not re-set. dp stays 1 after the next frame boundary.
4. Overflow:
   - Stimulus: push 3, 7, B, F, 4.
   - Required: the oldest (3) is dropped and digits show 7, B, F, 4.
   - dp=0 on digit 0 until the next frame boundary, then 1.
5. Reset mid-operation:
   - Stimulus: assert rst=0 during a push cycle.
   - Required: history cleared, outputs blank at once.
   - With HEX_HISTORY_BLANK_LEADING_EN, after one push of 4 only digit 0 lights (seg=19) and the others stay 7F.
6. Leading digits, macro undefined:
   - Stimulus: same stimulus as scenario 5.
   - Required: digits 1-3 show seg=40.
